// File: rtl/mayo_shake_unpack_if.sv
// BRAM read port plus nibble stream for mayo_shake_unpack.
// master = the unpacker (drives BRAM address/enable and the stream), slave = BRAM + consumer.
interface mayo_shake_unpack_if;
   logic [3:0]  BRAMA_we;
   logic [31:0] BRAMA_addr;
   logic [31:0] BRAMA_din;
   logic        BRAMA_en;
   logic [31:0] BRAMA_dout;
   logic        m_valid;
   logic [3:0]  m_data;
   logic        m_ready;

   modport master (
      output BRAMA_we, BRAMA_addr, BRAMA_din, BRAMA_en, m_valid, m_data,
      input  BRAMA_dout, m_ready
   );

   modport slave (
      input  BRAMA_we, BRAMA_addr, BRAMA_din, BRAMA_en, m_valid, m_data,
      output BRAMA_dout, m_ready
   );
endinterface

// File: rtl/mayo_shake_unpack.sv
// Reads SHAKE output words from BRAM and streams them as GF(16) nibbles, low nibble first.
// Optional handshake stall counter enabled by defining MAYO_UNPACK_PERF_EN.
//
// state | meaning
// IDLE  | waiting for en; latches src_adr/nlen
// RUN   | issuing reads (max 2 words buffered or in flight) and emitting nibbles
// DONE  | one-cycle done pulse, then back to IDLE
module mayo_shake_unpack #(
   parameter int C_BRAMSIZE = 31
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [31:0]          src_adr,
   input  logic [31:0]          nlen,
   mayo_shake_unpack_if.master  bus,
   output logic                 busy,
   output logic                 done,
   output logic [31:0]          stall_cnt
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [63:0] MASK64    = (64'd1 << C_BRAMSIZE) - 64'd1;
   localparam logic [31:0] ADDR_MASK = MASK64[31:0] & 32'hFFFF_FFFC;

   state_t      state, state_nx;
   logic [31:0] remaining;
   logic [31:0] words_left;
   logic [31:0] next_ptr;
   logic [31:0] rd_addr;
   logic        rd_en;
   logic        pend;
   logic [31:0] buf0, buf1;
   logic [1:0]  fcnt;
   logic [2:0]  nib;
   logic        busy_q;

   logic        start;
   logic        m_valid_i;
   logic        xfer;
   logic        pop;
   logic        push;
   logic        issue;
   logic [2:0]  occ;
   logic [31:0] src_al;
   logic [31:0] nwords;
   logic [31:0] head_sh;

   always_comb begin
      start     = (state == IDLE) && en;
      src_al    = src_adr & ADDR_MASK;
      nwords    = {3'b000, nlen[31:3]} + {31'b0, |nlen[2:0]};
      m_valid_i = (state == RUN) && (fcnt != 2'd0) && (remaining != 32'd0);
      xfer      = m_valid_i && bus.m_ready;
      // last nibble of a word, or last nibble overall (rest of a partial word is dropped)
      pop       = xfer && ((nib == 3'd7) || (remaining == 32'd1));
      push      = pend;
      occ       = {1'b0, fcnt} + {2'b00, rd_en} + {2'b00, pend};
      issue     = (state == RUN) && (words_left != 32'd0) &&
                  ((occ - {2'b00, pop}) < 3'd2);
      head_sh   = buf0 >> {27'd0, nib, 2'b00};
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (en) state_nx = RUN;
         RUN:     if (remaining == 32'd0) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         remaining  <= '0;
         words_left <= '0;
         next_ptr   <= '0;
         rd_addr    <= '0;
         rd_en      <= 1'b0;
         pend       <= 1'b0;
         buf0       <= '0;
         buf1       <= '0;
         fcnt       <= '0;
         nib        <= '0;
         busy_q     <= 1'b0;
      end else begin
         rd_en <= 1'b0;
         if (start) begin
            remaining <= nlen;
            nib       <= '0;
            fcnt      <= '0;
            pend      <= 1'b0;
            busy_q    <= (nlen != 32'd0);
            if (nlen != 32'd0) begin
               rd_en      <= 1'b1;
               rd_addr    <= src_al;
               next_ptr   <= (src_al + 32'd4) & ADDR_MASK;
               words_left <= nwords - 32'd1;
            end else begin
               words_left <= '0;
            end
         end else if (state == RUN) begin
            pend <= rd_en;
            if (remaining == 32'd0) busy_q <= 1'b0;
            if (issue) begin
               rd_en      <= 1'b1;
               rd_addr    <= next_ptr;
               next_ptr   <= (next_ptr + 32'd4) & ADDR_MASK;
               words_left <= words_left - 32'd1;
            end
            if (xfer) begin
               remaining <= remaining - 32'd1;
               nib       <= pop ? 3'd0 : nib + 3'd1;
            end
            // read data lands one cycle after the BRAM sampled the request
            case ({push, pop})
               2'b10: begin
                  if (fcnt == 2'd0) buf0 <= bus.BRAMA_dout;
                  else              buf1 <= bus.BRAMA_dout;
                  fcnt <= fcnt + 2'd1;
               end
               2'b01: begin
                  buf0 <= buf1;
                  fcnt <= fcnt - 2'd1;
               end
               2'b11: begin
                  if (fcnt == 2'd1) begin
                     buf0 <= bus.BRAMA_dout;
                  end else begin
                     buf0 <= buf1;
                     buf1 <= bus.BRAMA_dout;
                  end
               end
               default: ;
            endcase
         end else begin
            pend <= 1'b0;
         end
      end
   end

   assign bus.BRAMA_we   = 4'h0;
   assign bus.BRAMA_din  = 32'h0;
   assign bus.BRAMA_en   = rd_en;
   assign bus.BRAMA_addr = rd_addr;
   assign bus.m_valid    = m_valid_i;
   assign bus.m_data     = m_valid_i ? head_sh[3:0] : 4'h0;
   assign busy           = busy_q;
   assign done           = (state == DONE);

`ifdef MAYO_UNPACK_PERF_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk) begin
      if (rst)                                                   stall_q <= '0;
      else if (start)                                            stall_q <= '0;
      else if (m_valid_i && !bus.m_ready && (stall_q != '1))     stall_q <= stall_q + 32'd1;
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = 32'd0;
`endif

endmodule
